// File: rtl/lc3_mem_pkg.sv
// ============================================================================
// Module  : lc3_mem_pkg
// Brief   : Shared widths and access-controller state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lc3_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================================
// Module  : mem_timeout_ctr
// Brief   : REQ-state wait counter with terminal-count flag (MEM_TIMEOUT_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic hold,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Count stays cleared outside REQ, so every REQ entry starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!active) begin
      r_count <= '0;
    end else if (!hold && !tc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tc = active && (r_count == c_LAST);

endmodule
`endif

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module  : mem_access_ctrl
// Brief   : MAR/MDR holder and IDLE/REQ/DONE memory handshake controller.
//           Optional REQ timeout compiled in with `define MEM_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_mar,
  input  logic [ADDR_W-1:0] mar_in,
  input  logic              ld_mdr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mio_en,
  input  logic              r_w,
  output logic [ADDR_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err
);

  mem_state_e        r_state;
  mem_state_e        w_next_state;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic              r_we;
  logic              w_in_req;
  logic              w_timeout;
  logic              w_err_flag;

  assign w_in_req = (r_state == REQ);

`ifdef MEM_TIMEOUT_EN
  logic w_tc;
  logic r_err;

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .active(w_in_req),
    .hold  (mem_ack),
    .tc    (w_tc)
  );

  // An ack on the terminal-count cycle is a normal completion.
  assign w_timeout = w_tc && !mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_in_req && w_timeout;
    end
  end

  assign w_err_flag = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign w_err_flag       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (mio_en) w_next_state = REQ;
      REQ:     if (mem_ack || w_timeout) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    unique case (r_state)
      REQ: begin
        mem_req = 1'b1;
        mem_we  = r_we;
      end
      DONE: begin
        mem_ready = 1'b1;
        mem_err   = w_err_flag;
      end
      default: ;
    endcase
  end

  // MAR/MDR are writable from the datapath only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mar <= '0;
      r_mdr <= '0;
      r_we  <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        if (ld_mar) r_mar <= mar_in;
        if (ld_mdr) r_mdr <= bus_in;
        if (mio_en) r_we  <= r_w;
      end else if (w_in_req && mem_ack && !r_we) begin
        r_mdr <= mem_rdata;
      end
    end
  end

  assign mar_out   = r_mar;
  assign mdr_out   = r_mdr;
  assign mem_addr  = r_mar;
  assign mem_wdata = r_mdr;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module  : tb_mem_access_ctrl
// Brief   : Directed plus randomized checks of mem_access_ctrl against a
//           transaction-level model (timeout checks need MEM_TIMEOUT_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_mar = 1'b0;
  logic [15:0] mar_in = '0;
  logic        ld_mdr = 1'b0;
  logic [15:0] bus_in = '0;
  logic        mio_en = 1'b0;
  logic        r_w = 1'b0;
  logic [15:0] mar_out;
  logic [15:0] mdr_out;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model: what MAR/MDR must hold between transactions.
  logic [15:0] exp_mar = '0;
  logic [15:0] exp_mdr = '0;

`ifdef MEM_TIMEOUT_EN
  localparam int MAX_WAIT = 3;
`else
  localparam int MAX_WAIT = 6;
`endif

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_mar   (ld_mar),
    .mar_in   (mar_in),
    .ld_mdr   (ld_mdr),
    .bus_in   (bus_in),
    .mio_en   (mio_en),
    .r_w      (r_w),
    .mar_out  (mar_out),
    .mdr_out  (mdr_out),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ld_mar  = 1'b0;
    ld_mdr  = 1'b0;
    mio_en  = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},   32'(mem_req),   0);
    check({tag, "_ready"}, 32'(mem_ready), 0);
    check({tag, "_we"},    32'(mem_we),    0);
    check({tag, "_err"},   32'(mem_err),   0);
    check({tag, "_mar"},   32'(mar_out),   32'(exp_mar));
    check({tag, "_mdr"},   32'(mdr_out),   32'(exp_mdr));
  endtask

  // One complete access: ack arrives after 'waits' idle REQ cycles.
  task automatic do_access(input logic [15:0] addr, input logic [15:0] data,
                           input logic [15:0] rdata, input logic rw,
                           input logic load_mdr, input logic same,
                           input logic noise, input int waits);
    ld_mar = 1'b1; mar_in = addr; ld_mdr = load_mdr; bus_in = data;
    r_w = rw; mio_en = same;
    exp_mar = addr;
    if (load_mdr) exp_mdr = data;
    if (!same) begin
      tick();
      ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b1;
    end
    tick();
    ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      check("req_high",  32'(mem_req),   1);
      check("req_addr",  32'(mem_addr),  32'(exp_mar));
      check("req_wdata", 32'(mem_wdata), 32'(exp_mdr));
      check("req_we",    32'(mem_we),    32'(rw));
      check("req_ready", 32'(mem_ready), 0);
      check("req_mdr",   32'(mdr_out),   32'(exp_mdr));
      if (noise) begin
        ld_mar = 1'b1; mar_in = 16'($urandom);
        ld_mdr = 1'b1; bus_in = 16'($urandom);
        mio_en = 1'b1; r_w = ~rw;
      end
      mem_ack   = (i == waits);
      mem_rdata = (i == waits) ? rdata : 16'($urandom);
      tick();
    end
    if (!rw) exp_mdr = rdata;
    clear_inputs();
    mio_en = 1'($urandom);
    check("done_ready", 32'(mem_ready), 1);
    check("done_req",   32'(mem_req),   0);
    check("done_we",    32'(mem_we),    0);
    check("done_err",   32'(mem_err),   0);
    check("done_mdr",   32'(mdr_out),   32'(exp_mdr));
    check("done_mar",   32'(mar_out),   32'(exp_mar));
    tick();
    mio_en = 1'b0;
    check_idle("after_done");
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic do_timeout(input logic [15:0] addr, input logic rw);
    ld_mar = 1'b1; mar_in = addr; r_w = rw; mio_en = 1'b1;
    exp_mar = addr;
    tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      check("to_req",   32'(mem_req),   1);
      check("to_ready", 32'(mem_ready), 0);
      mem_rdata = 16'($urandom);
      tick();
    end
    check("to_done_ready", 32'(mem_ready), 1);
    check("to_done_err",   32'(mem_err),   1);
    check("to_done_req",   32'(mem_req),   0);
    check("to_done_mdr",   32'(mdr_out),   32'(exp_mdr));
    tick();
    check_idle("to_after");
  endtask
`endif

  initial begin
    logic [15:0] junk;

    // Reset state
    #3;
    check("rst_req",   32'(mem_req),   0);
    check("rst_mar",   32'(mar_out),   0);
    check("rst_mdr",   32'(mdr_out),   0);
    check("rst_addr",  32'(mem_addr),  0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_ready", 32'(mem_ready), 0);
    check("rst_err",   32'(mem_err),   0);
    check("rst_we",    32'(mem_we),    0);
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("post_rst");

    // Zero-wait read, then three-wait write
    do_access(16'h3000, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("read_mdr", 32'(mdr_out), 32'hBEEF);
    do_access(16'h4005, 16'h1234, 16'h9999, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    check("write_mdr", 32'(mdr_out), 32'h1234);

    // Datapath loads while in REQ must be ignored
    do_access(16'h0100, 16'h0F0F, 16'h7777, 1'b0, 1'b1, 1'b1, 1'b1, 2);

    // Ack outside REQ does nothing
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    tick();
    mem_ack = 1'b0;
    check_idle("stray_ack");

    // Randomized accesses
    for (int t = 0; t < 25; t++) begin
      do_access(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(MAX_WAIT, 0)));
    end

    // Asynchronous reset in the middle of a REQ
    ld_mar = 1'b1; mar_in = 16'h6000; ld_mdr = 1'b1; bus_in = 16'h5A5A;
    r_w = 1'b0; mio_en = 1'b1;
    tick();
    clear_inputs();
    check("pre_rst_req", 32'(mem_req), 1);
    #2;
    rst_n = 1'b0; mem_ack = 1'b1; junk = 16'($urandom); mem_rdata = junk;
    #1;
    exp_mar = '0; exp_mdr = '0;
    check("arst_req",  32'(mem_req),  0);
    check("arst_mar",  32'(mar_out),  0);
    check("arst_mdr",  32'(mdr_out),  0);
    check("arst_addr", 32'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("arst_after");
    end
    mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    do_access(16'h7000, 16'h2468, 16'h1357, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    do_timeout(16'h7100, 1'b0);
    do_timeout(16'h7200, 1'b1);
    do_access(16'h7300, 16'h1111, 16'hC0DE, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    check("to_ack_last_mdr", 32'(mdr_out), 32'hC0DE);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
